id_ex_pipeline_register: RTL and testbench

- Pipeline register between the Decode (ID) and Execute (EX) stages of the Osiris I five-stage RV32I core.
- Captures the register-file read data, PC values, the 32-bit sign-extended immediate from the extend unit, register indices and decoded control bits. Presents them to the EX stage one cycle later.
- Supports stall (hold), flush (bubble insertion) and a saturating bubble counter for performance monitoring.

---
 rtl/osiris_pkg.sv | 25 ++
 rtl/sat_counter.sv | 22 ++
 rtl/id_ex_pipeline_register.sv | 120 ++++++++++++
 tb/tb_id_ex_pipeline_register.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/osiris_pkg.sv
// Shared Osiris I core types and widths used by the decode and execute stages.
// Holds field widths, the packed control bundle and the bubble encoding.
package osiris_pkg;

    localparam int XLEN         = 32;
    localparam int REG_IDX_W    = 5;
    localparam int ALU_CTRL_W   = 4;
    localparam int RESULT_SRC_W = 2;

    typedef struct packed {
        logic                    reg_write;
        logic [RESULT_SRC_W-1:0] result_src;
        logic                    mem_write;
        logic                    jump;
        logic                    branch;
        logic [ALU_CTRL_W-1:0]   alu_control;
        logic                    alu_src;
        logic [2:0]              funct3;
        logic                    valid;
    } id_ex_ctrl_t;

    // All-zero control is a NOP: no writeback, no store, no redirect, not valid.
    localparam id_ex_ctrl_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Generic W-bit saturating event counter, one increment per clock with inc high.
// Never stalls; holds at all-ones once saturated instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID->EX pipeline register: 1-cycle latency, flush inserts an all-zero bubble.
// Stall (i_en_EX low) holds every output; flush overrides stall.
module id_ex_pipeline_register
    import osiris_pkg::*;
#(
    parameter int XLEN  = osiris_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en_EX,
    input  logic                    i_flush_EX,
    input  logic                    i_valid_ID,
    input  logic [XLEN-1:0]         i_pc_ID,
    input  logic [XLEN-1:0]         i_pc_plus4_ID,
    input  logic [XLEN-1:0]         i_rd1_ID,
    input  logic [XLEN-1:0]         i_rd2_ID,
    input  logic [XLEN-1:0]         i_imm_ex_ID,
    input  logic [REG_IDX_W-1:0]    i_rs1_ID,
    input  logic [REG_IDX_W-1:0]    i_rs2_ID,
    input  logic [REG_IDX_W-1:0]    i_rd_ID,
    input  logic [2:0]              i_funct3_ID,
    input  logic [ALU_CTRL_W-1:0]   i_alu_control_ID,
    input  logic                    i_alu_src_ID,
    input  logic [RESULT_SRC_W-1:0] i_result_src_ID,
    input  logic                    i_reg_write_ID,
    input  logic                    i_mem_write_ID,
    input  logic                    i_branch_ID,
    input  logic                    i_jump_ID,
    output logic                    o_valid_EX,
    output logic [XLEN-1:0]         o_pc_EX,
    output logic [XLEN-1:0]         o_pc_plus4_EX,
    output logic [XLEN-1:0]         o_rd1_EX,
    output logic [XLEN-1:0]         o_rd2_EX,
    output logic [XLEN-1:0]         o_imm_ex_EX,
    output logic [REG_IDX_W-1:0]    o_rs1_EX,
    output logic [REG_IDX_W-1:0]    o_rs2_EX,
    output logic [REG_IDX_W-1:0]    o_rd_EX,
    output logic [2:0]              o_funct3_EX,
    output logic [ALU_CTRL_W-1:0]   o_alu_control_EX,
    output logic                    o_alu_src_EX,
    output logic [RESULT_SRC_W-1:0] o_result_src_EX,
    output logic                    o_reg_write_EX,
    output logic                    o_mem_write_EX,
    output logic                    o_branch_EX,
    output logic                    o_jump_EX,
    output logic [CNT_W-1:0]        o_bubble_cnt
);

    id_ex_ctrl_t ctrl_d;
    id_ex_ctrl_t ctrl_q;

    always_comb begin
        ctrl_d             = ID_EX_BUBBLE;
        ctrl_d.reg_write   = i_reg_write_ID;
        ctrl_d.result_src  = i_result_src_ID;
        ctrl_d.mem_write   = i_mem_write_ID;
        ctrl_d.jump        = i_jump_ID;
        ctrl_d.branch      = i_branch_ID;
        ctrl_d.alu_control = i_alu_control_ID;
        ctrl_d.alu_src     = i_alu_src_ID;
        ctrl_d.funct3      = i_funct3_ID;
        ctrl_d.valid       = i_valid_ID;
    end

    // Flush is checked before enable so a stalled ID cannot pin a squashed op in EX.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl_q        <= ID_EX_BUBBLE;
            o_pc_EX       <= '0;
            o_pc_plus4_EX <= '0;
            o_rd1_EX      <= '0;
            o_rd2_EX      <= '0;
            o_imm_ex_EX   <= '0;
            o_rs1_EX      <= '0;
            o_rs2_EX      <= '0;
            o_rd_EX       <= '0;
        end else if (i_flush_EX) begin
            ctrl_q        <= ID_EX_BUBBLE;
            o_pc_EX       <= '0;
            o_pc_plus4_EX <= '0;
            o_rd1_EX      <= '0;
            o_rd2_EX      <= '0;
            o_imm_ex_EX   <= '0;
            o_rs1_EX      <= '0;
            o_rs2_EX      <= '0;
            o_rd_EX       <= '0;
        end else if (i_en_EX) begin
            ctrl_q        <= ctrl_d;
            o_pc_EX       <= i_pc_ID;
            o_pc_plus4_EX <= i_pc_plus4_ID;
            o_rd1_EX      <= i_rd1_ID;
            o_rd2_EX      <= i_rd2_ID;
            o_imm_ex_EX   <= i_imm_ex_ID;
            o_rs1_EX      <= i_rs1_ID;
            o_rs2_EX      <= i_rs2_ID;
            o_rd_EX       <= i_rd_ID;
        end
    end

    assign o_valid_EX       = ctrl_q.valid;
    assign o_reg_write_EX   = ctrl_q.reg_write;
    assign o_result_src_EX  = ctrl_q.result_src;
    assign o_mem_write_EX   = ctrl_q.mem_write;
    assign o_jump_EX        = ctrl_q.jump;
    assign o_branch_EX      = ctrl_q.branch;
    assign o_alu_control_EX = ctrl_q.alu_control;
    assign o_alu_src_EX     = ctrl_q.alu_src;
    assign o_funct3_EX      = ctrl_q.funct3;

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (i_flush_EX),
        .cnt   (o_bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed vector table, async-reset and
// saturation sequences, then random traffic against a next-state reference model.
module tb_id_ex_pipeline_register;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_control;
        logic        alu_src;
        logic [1:0]  result_src;
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
    } fields_t;

    typedef struct {
        logic    en;
        logic    flush;
        fields_t in;
        fields_t exp;
        int      cnt;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_en_EX = 1'b0;
    logic i_flush_EX = 1'b0;
    fields_t drv = '0;
    fields_t dut_out, sml_out;
    logic [15:0] big_cnt;
    logic [3:0]  sml_cnt;

    logic        i_valid_ID, i_alu_src_ID, i_reg_write_ID, i_mem_write_ID, i_branch_ID, i_jump_ID;
    logic [31:0] i_pc_ID, i_pc_plus4_ID, i_rd1_ID, i_rd2_ID, i_imm_ex_ID;
    logic [4:0]  i_rs1_ID, i_rs2_ID, i_rd_ID;
    logic [2:0]  i_funct3_ID;
    logic [3:0]  i_alu_control_ID;
    logic [1:0]  i_result_src_ID;

    logic        o_valid_EX, o_alu_src_EX, o_reg_write_EX, o_mem_write_EX, o_branch_EX, o_jump_EX;
    logic [31:0] o_pc_EX, o_pc_plus4_EX, o_rd1_EX, o_rd2_EX, o_imm_ex_EX;
    logic [4:0]  o_rs1_EX, o_rs2_EX, o_rd_EX;
    logic [2:0]  o_funct3_EX;
    logic [3:0]  o_alu_control_EX;
    logic [1:0]  o_result_src_EX;

    logic        s_valid, s_alu_src, s_reg_write, s_mem_write, s_branch, s_jump;
    logic [31:0] s_pc, s_pc_plus4, s_rd1, s_rd2, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_funct3;
    logic [3:0]  s_alu_control;
    logic [1:0]  s_result_src;

    assign {i_valid_ID, i_pc_ID, i_pc_plus4_ID, i_rd1_ID, i_rd2_ID, i_imm_ex_ID, i_rs1_ID,
            i_rs2_ID, i_rd_ID, i_funct3_ID, i_alu_control_ID, i_alu_src_ID, i_result_src_ID,
            i_reg_write_ID, i_mem_write_ID, i_branch_ID, i_jump_ID} = drv;
    assign dut_out = {o_valid_EX, o_pc_EX, o_pc_plus4_EX, o_rd1_EX, o_rd2_EX, o_imm_ex_EX,
                      o_rs1_EX, o_rs2_EX, o_rd_EX, o_funct3_EX, o_alu_control_EX, o_alu_src_EX,
                      o_result_src_EX, o_reg_write_EX, o_mem_write_EX, o_branch_EX, o_jump_EX};
    assign sml_out = {s_valid, s_pc, s_pc_plus4, s_rd1, s_rd2, s_imm, s_rs1, s_rs2, s_rd,
                      s_funct3, s_alu_control, s_alu_src, s_result_src, s_reg_write,
                      s_mem_write, s_branch, s_jump};

    always #5 i_clk = ~i_clk;

    id_ex_pipeline_register #(.XLEN(32), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en_EX(i_en_EX), .i_flush_EX(i_flush_EX),
        .i_valid_ID(i_valid_ID), .i_pc_ID(i_pc_ID), .i_pc_plus4_ID(i_pc_plus4_ID),
        .i_rd1_ID(i_rd1_ID), .i_rd2_ID(i_rd2_ID), .i_imm_ex_ID(i_imm_ex_ID),
        .i_rs1_ID(i_rs1_ID), .i_rs2_ID(i_rs2_ID), .i_rd_ID(i_rd_ID),
        .i_funct3_ID(i_funct3_ID), .i_alu_control_ID(i_alu_control_ID),
        .i_alu_src_ID(i_alu_src_ID), .i_result_src_ID(i_result_src_ID),
        .i_reg_write_ID(i_reg_write_ID), .i_mem_write_ID(i_mem_write_ID),
        .i_branch_ID(i_branch_ID), .i_jump_ID(i_jump_ID),
        .o_valid_EX(o_valid_EX), .o_pc_EX(o_pc_EX), .o_pc_plus4_EX(o_pc_plus4_EX),
        .o_rd1_EX(o_rd1_EX), .o_rd2_EX(o_rd2_EX), .o_imm_ex_EX(o_imm_ex_EX),
        .o_rs1_EX(o_rs1_EX), .o_rs2_EX(o_rs2_EX), .o_rd_EX(o_rd_EX),
        .o_funct3_EX(o_funct3_EX), .o_alu_control_EX(o_alu_control_EX),
        .o_alu_src_EX(o_alu_src_EX), .o_result_src_EX(o_result_src_EX),
        .o_reg_write_EX(o_reg_write_EX), .o_mem_write_EX(o_mem_write_EX),
        .o_branch_EX(o_branch_EX), .o_jump_EX(o_jump_EX), .o_bubble_cnt(big_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    id_ex_pipeline_register #(.XLEN(32), .CNT_W(4)) dut_small (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en_EX(i_en_EX), .i_flush_EX(i_flush_EX),
        .i_valid_ID(i_valid_ID), .i_pc_ID(i_pc_ID), .i_pc_plus4_ID(i_pc_plus4_ID),
        .i_rd1_ID(i_rd1_ID), .i_rd2_ID(i_rd2_ID), .i_imm_ex_ID(i_imm_ex_ID),
        .i_rs1_ID(i_rs1_ID), .i_rs2_ID(i_rs2_ID), .i_rd_ID(i_rd_ID),
        .i_funct3_ID(i_funct3_ID), .i_alu_control_ID(i_alu_control_ID),
        .i_alu_src_ID(i_alu_src_ID), .i_result_src_ID(i_result_src_ID),
        .i_reg_write_ID(i_reg_write_ID), .i_mem_write_ID(i_mem_write_ID),
        .i_branch_ID(i_branch_ID), .i_jump_ID(i_jump_ID),
        .o_valid_EX(s_valid), .o_pc_EX(s_pc), .o_pc_plus4_EX(s_pc_plus4),
        .o_rd1_EX(s_rd1), .o_rd2_EX(s_rd2), .o_imm_ex_EX(s_imm),
        .o_rs1_EX(s_rs1), .o_rs2_EX(s_rs2), .o_rd_EX(s_rd),
        .o_funct3_EX(s_funct3), .o_alu_control_EX(s_alu_control),
        .o_alu_src_EX(s_alu_src), .o_result_src_EX(s_result_src),
        .o_reg_write_EX(s_reg_write), .o_mem_write_EX(s_mem_write),
        .o_branch_EX(s_branch), .o_jump_EX(s_jump), .o_bubble_cnt(sml_cnt)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_f(input string name, input fields_t got, input fields_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_c(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    function automatic fields_t fill(input logic [31:0] w);
        fields_t f;
        f.valid = w[0];       f.pc = w;               f.pc_plus4 = w + 32'd4;
        f.rd1 = w;            f.rd2 = ~w;             f.imm = w ^ 32'h5A5A_5A5A;
        f.rs1 = w[4:0];       f.rs2 = w[9:5];         f.rd = w[14:10];
        f.funct3 = w[2:0];    f.alu_control = w[7:4]; f.alu_src = w[1];
        f.result_src = w[3:2]; f.reg_write = w[0];    f.mem_write = w[0];
        f.branch = w[2];      f.jump = w[3];
        return f;
    endfunction

    function automatic fields_t rnd();
        fields_t f;
        f = fill($urandom);
        f.rd2 = $urandom;
        f.imm = $urandom;
        f.rd = 5'($urandom);
        f.valid = 1'($urandom);
        f.reg_write = 1'($urandom);
        f.mem_write = 1'($urandom);
        return f;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    vec_t    vt[10];
    fields_t a_f, d_f, p0, p1, p2, nv, exp_f;
    int      nf;

    initial begin
        a_f = '0;
        a_f.valid = 1'b1; a_f.imm = 32'hFFFF_F800; a_f.pc = 32'h0000_0100;
        a_f.rd = 5'd10;   a_f.reg_write = 1'b1;
        d_f = fill(32'hDEAD_BEEF);
        p0 = fill(32'h0000_0200); p0.valid = 1'b1;
        p1 = fill(32'h0000_0204); p1.valid = 1'b1;
        p2 = fill(32'h0000_0208); p2.valid = 1'b1;
        nv = fill(32'hFFFF_FFFF); nv.valid = 1'b0;

        vt[0] = '{1'b1, 1'b0, a_f, a_f, 0};
        vt[1] = '{1'b0, 1'b0, d_f, a_f, 0};
        vt[2] = '{1'b0, 1'b0, d_f, a_f, 0};
        vt[3] = '{1'b0, 1'b0, d_f, a_f, 0};
        vt[4] = '{1'b1, 1'b0, d_f, d_f, 0};
        vt[5] = '{1'b0, 1'b1, d_f, '0,  1};
        vt[6] = '{1'b1, 1'b0, p0,  p0,  1};
        vt[7] = '{1'b1, 1'b1, p1,  '0,  2};
        vt[8] = '{1'b1, 1'b0, p2,  p2,  2};
        vt[9] = '{1'b1, 1'b0, nv,  nv,  2};

        // Reset held across edges with live random inputs.
        i_rst_n = 1'b0; i_en_EX = 1'b1; i_flush_EX = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drv = rnd();
            tick();
        end
        check_f("reset_fields", dut_out, '0);
        check_c("reset_cnt", int'(big_cnt), 0);
        i_rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            i_en_EX = vt[i].en; i_flush_EX = vt[i].flush; drv = vt[i].in;
            tick();
            check_f($sformatf("vec%0d_fields", i), dut_out, vt[i].exp);
            check_c($sformatf("vec%0d_cnt", i), int'(big_cnt), vt[i].cnt);
            check_c($sformatf("vec%0d_cnt4", i), int'(sml_cnt), vt[i].cnt);
        end

        // Async reset between edges clears loaded contents with no clock.
        i_en_EX = 1'b1; i_flush_EX = 1'b0; drv = d_f;
        tick();
        #2 i_rst_n = 1'b0;
        #1;
        check_f("async_rst_fields", dut_out, '0);
        check_c("async_rst_cnt", int'(big_cnt), 0);
        #1 i_rst_n = 1'b1;

        // Twenty flushes, held in stall, with mem_write asserted at the input.
        i_en_EX = 1'b0; i_flush_EX = 1'b1; drv = d_f;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check_c($sformatf("sat_cnt4_%0d", k), int'(sml_cnt), sat(k, 15));
            check_c($sformatf("sat_cnt16_%0d", k), int'(big_cnt), k);
        end
        check_f("sat_fields", sml_out, '0);

        exp_f = '0;
        nf = 20;
        for (int k = 0; k < 400; k++) begin
            i_en_EX = ($urandom_range(0, 3) != 0);
            i_flush_EX = ($urandom_range(0, 7) == 0);
            drv = rnd();
            if (i_flush_EX) begin
                exp_f = '0;
                nf++;
            end else if (i_en_EX) begin
                exp_f = drv;
            end
            tick();
            check_f($sformatf("rnd%0d_fields", k), dut_out, exp_f);
            check_c($sformatf("rnd%0d_cnt16", k), int'(big_cnt), sat(nf, 65535));
            check_c($sformatf("rnd%0d_cnt4", k), int'(sml_cnt), sat(nf, 15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
